// File: rtl/coreinfo_strings_pkg.sv
// Register-map constants shared by the ZX-UNO register peripherals,
// plus the per-channel read-state type used by the core-info strings block.
package coreinfo_strings_pkg;

  // ZX-UNO register addresses owned by the core-info block
  localparam logic [7:0] COREID_ADDR        = 8'hFF;
  localparam logic [7:0] COREINFO_BASE_ADDR = 8'hFD;

  // Value returned for padding bytes and for an exhausted non-wrapping string
  localparam logic [7:0] ASCII_NUL = 8'h00;

  // Read tracking for one string channel
  typedef enum logic {
    CH_IDLE    = 1'b0,
    CH_READING = 1'b1
  } chan_state_e;

  // Register address of channel k when channel 0 sits at base
  function automatic logic [7:0] chan_addr(input logic [7:0] base, input int unsigned k);
    logic [7:0] w_off;
    w_off = k[7:0];
    return base + w_off;
  endfunction

endpackage

// File: rtl/coreinfo_chan.sv
// One string channel: byte pointer that advances once per completed register read.
//
// state      | meaning
// -----------+----------------------------------------------------------------
// CH_IDLE    | no read in progress on this channel; pointer holds
// CH_READING | register read strobe seen on this channel; pointer frozen so the
//            | byte stays stable, advanced once when the read ends
module coreinfo_chan
  import coreinfo_strings_pkg::*;
#(
  parameter int STR_LEN = 16,
  parameter bit WRAP    = 1'b1,
  parameter int PTR_W   = $clog2(STR_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel_rd,
  input  logic             rewind,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST_P = PTR_W'(STR_LEN - 1);
  localparam logic [PTR_W-1:0] END_P  = PTR_W'(STR_LEN);

  chan_state_e      r_state;
  logic [PTR_W-1:0] r_ptr;

  // Rewind beats an active read; the pointer only moves on the cycle a read ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CH_IDLE;
      r_ptr   <= '0;
    end else if (rewind) begin
      r_state <= CH_IDLE;
      r_ptr   <= '0;
    end else if (sel_rd) begin
      r_state <= CH_READING;
    end else if (r_state == CH_READING) begin
      r_state <= CH_IDLE;
      if (r_ptr == LAST_P) begin
        r_ptr <= WRAP ? '0 : END_P;
      end else if (r_ptr < LAST_P) begin
        r_ptr <= r_ptr + PTR_W'(1);
      end
    end
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/coreinfo_strings.sv
// N_STR read-only ASCII strings on consecutive ZX-UNO register addresses.
// Each channel keeps its own byte pointer; the top decodes the address,
// picks the channel's current byte and drives the read-mux data/enable.
module coreinfo_strings
  import coreinfo_strings_pkg::*;
#(
  parameter int                          N_STR     = 3,
  parameter int                          STR_LEN   = 16,
  parameter logic [7:0]                  BASE_ADDR = COREINFO_BASE_ADDR,
  parameter int                          WRAP      = 1,
  parameter logic [N_STR*STR_LEN*8-1:0]  TEXT      = '0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] zxuno_addr,
  input  logic       zxuno_regrd,
  input  logic       zxuno_regwr,
  input  logic       regaddr_changed,
  output logic [7:0] dout,
  output logic       oe_n
);

  localparam int PTR_W     = $clog2(STR_LEN + 1);
  // Byte table is padded to the full pointer range so every pointer value,
  // including the saturated end position, indexes a NUL rather than out of range
  localparam int ROM_DEPTH = 2 ** PTR_W;

  logic [N_STR-1:0] w_hit;
  logic [N_STR-1:0] w_sel_rd;
  logic [N_STR-1:0] w_rewind;
  logic [PTR_W-1:0] w_ptr  [N_STR];
  logic [7:0]       w_byte [N_STR];
  logic [7:0]       w_rom  [N_STR][ROM_DEPTH];
  logic [7:0]       w_dout;
  logic             w_any_rd;

  for (genvar g = 0; g < N_STR; g++) begin : g_chan
    localparam logic [7:0] CH_ADDR = chan_addr(BASE_ADDR, g);

    assign w_hit[g]    = (zxuno_addr == CH_ADDR);
    assign w_sel_rd[g] = w_hit[g] & zxuno_regrd;
    assign w_rewind[g] = w_hit[g] & (regaddr_changed | zxuno_regwr);

    for (genvar j = 0; j < ROM_DEPTH; j++) begin : g_byte
      if (j < STR_LEN) begin : g_text
        assign w_rom[g][j] = TEXT[((g*STR_LEN)+j)*8 +: 8];
      end else begin : g_pad
        assign w_rom[g][j] = ASCII_NUL;
      end
    end

    assign w_byte[g] = w_rom[g][w_ptr[g]];

    coreinfo_chan #(
      .STR_LEN (STR_LEN),
      .WRAP    (WRAP != 0),
      .PTR_W   (PTR_W)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .sel_rd (w_sel_rd[g]),
      .rewind (w_rewind[g]),
      .ptr    (w_ptr[g])
    );
  end

  assign w_any_rd = |w_sel_rd;

  // Channel addresses are distinct, so at most one channel drives the data
  always_comb begin
    w_dout = ASCII_NUL;
    for (int k = 0; k < N_STR; k++) begin
      if (w_sel_rd[k]) begin
        w_dout = w_byte[k];
      end
    end
  end

  assign dout = w_dout;
  assign oe_n = ~w_any_rd;

endmodule

// File: tb/tb_coreinfo_strings.sv
module tb_coreinfo_strings;

  localparam int         NS   = 3;
  localparam int         SL   = 16;
  localparam logic [7:0] BASE = 8'hFD;
  // ch0 = "ABCDEFGHIJKLMNOP", ch1 = "abcdefghijklmnop", ch2 = "T20-07122015" + 4 NULs
  localparam logic [NS*SL*8-1:0] TEXT = {
    128'h00000000_35313032_32313730_2D303254,
    128'h706F6E6D_6C6B6A69_68676665_64636261,
    128'h504F4E4D_4C4B4A49_48474645_44434241
  };

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] zxuno_addr = 8'h00;
  logic       zxuno_regrd = 1'b0;
  logic       zxuno_regwr = 1'b0;
  logic       regaddr_changed = 1'b0;
  logic [7:0] dout_w, dout_s;
  logic       oe_w, oe_s;

  always #5 clk = ~clk;

  coreinfo_strings #(.N_STR(NS), .STR_LEN(SL), .BASE_ADDR(BASE), .WRAP(1), .TEXT(TEXT)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .zxuno_addr(zxuno_addr), .zxuno_regrd(zxuno_regrd),
    .zxuno_regwr(zxuno_regwr), .regaddr_changed(regaddr_changed), .dout(dout_w), .oe_n(oe_w));

  coreinfo_strings #(.N_STR(NS), .STR_LEN(SL), .BASE_ADDR(BASE), .WRAP(0), .TEXT(TEXT)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .zxuno_addr(zxuno_addr), .zxuno_regrd(zxuno_regrd),
    .zxuno_regwr(zxuno_regwr), .regaddr_changed(regaddr_changed), .dout(dout_s), .oe_n(oe_s));

  // ---------------- reference model (index 0 = wrapping, 1 = saturating) ----
  int m_ptr [2][NS];
  bit m_rd  [2][NS];

  function automatic int text_byte(input int k, input int j);
    return int'(TEXT[((k*SL)+j)*8 +: 8]);
  endfunction

  function automatic int hit_ch();
    if (zxuno_addr >= BASE && int'(zxuno_addr - BASE) < NS) return int'(zxuno_addr - BASE);
    return -1;
  endfunction

  function automatic int next_ptr(input int d, input int p);
    if (d == 0) return (p + 1) % SL;
    return (p + 1 > SL) ? SL : p + 1;
  endfunction

  function automatic int exp_dout(input int d);
    int ch, p;
    ch = hit_ch();
    if (ch < 0 || !zxuno_regrd) return 0;
    p = m_ptr[d][ch];
    return (p < SL) ? text_byte(ch, p) : 0;
  endfunction

  function automatic int exp_oe();
    return (hit_ch() >= 0 && zxuno_regrd) ? 0 : 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++)
        for (int k = 0; k < NS; k++) begin
          m_ptr[d][k] <= 0;
          m_rd[d][k]  <= 1'b0;
        end
    end else begin
      for (int d = 0; d < 2; d++)
        for (int k = 0; k < NS; k++) begin
          if (hit_ch() == k && (regaddr_changed || zxuno_regwr)) begin
            m_ptr[d][k] <= 0;
            m_rd[d][k]  <= 1'b0;
          end else if (hit_ch() == k && zxuno_regrd) begin
            m_rd[d][k] <= 1'b1;
          end else if (m_rd[d][k]) begin
            m_rd[d][k]  <= 1'b0;
            m_ptr[d][k] <= next_ptr(d, m_ptr[d][k]);
          end
        end
    end
  end

  // ---------------- checking ----------------
  int   n_pass = 0;
  int   n_total = 0;
  bit   chk_en = 1'b0;
  logic [1:0] lit_on = 2'b00;
  int   lit_val [2];
  bit   lit_oe = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("dout_wrap", int'(dout_w), exp_dout(0));
      chk("oe_n_wrap", int'(oe_w),   exp_oe());
      chk("dout_sat",  int'(dout_s), exp_dout(1));
      chk("oe_n_sat",  int'(oe_s),   exp_oe());
      if (lit_on[0]) begin
        chk("lit_dout_wrap", int'(dout_w), lit_val[0]);
        chk("lit_oe_wrap",   int'(oe_w),   int'(lit_oe));
      end
      if (lit_on[1]) begin
        chk("lit_dout_sat", int'(dout_s), lit_val[1]);
        chk("lit_oe_sat",   int'(oe_s),   int'(lit_oe));
      end
    end
  end

  // ---------------- stimulus ----------------
  int c2 [16] = '{'h54, 'h32, 'h30, 'h2D, 'h30, 'h37, 'h31, 'h32,
                  'h32, 'h30, 'h31, 'h35, 0, 0, 0, 0};

  task automatic set_lit(input int e0, input int e1, input bit oe);
    lit_on     = {e1 >= 0, e0 >= 0};
    lit_val[0] = e0;
    lit_val[1] = e1;
    lit_oe     = oe;
  endtask

  // One register read of n cycles; e0/e1 are literal expectations (-1 = none)
  task automatic rd(input logic [7:0] a, input int n, input int e0, input int e1, input bit oe = 1'b0);
    @(posedge clk); #2;
    zxuno_addr  = a;
    zxuno_regrd = 1'b1;
    set_lit(e0, e1, oe);
    repeat (n) @(negedge clk);
    #1 lit_on = 2'b00;
    @(posedge clk); #2;
    zxuno_regrd = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] a, input bit rac, input bit wr);
    @(posedge clk); #2;
    zxuno_addr      = a;
    regaddr_changed = rac;
    zxuno_regwr     = wr;
    @(posedge clk); #2;
    regaddr_changed = 1'b0;
    zxuno_regwr     = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    zxuno_regrd = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    zxuno_addr = 8'hFF;
    #7 chk_en = 1'b1;
    set_lit(0, 0, 1'b1);
    @(negedge clk); #1 lit_on = 2'b00;
    @(posedge clk); #2 rst_n = 1'b1;

    // core-ID string through its end, wrap vs. saturate
    for (int i = 0; i < 16; i++) rd(8'hFF, 1, c2[i], c2[i]);
    rd(8'hFF, 1, 'h54, 0);
    rd(8'hFF, 1, 'h32, 0);
    rd(8'hFF, 2, 'h30, 0);

    // rewind via address write and via data write; foreign address is ignored
    do_reset();
    rd(8'hFD, 1, 'h41, 'h41);
    rd(8'hFD, 1, 'h42, 'h42);
    rd(8'hFD, 1, 'h43, 'h43);
    pulse(8'hFD, 1'b1, 1'b0);
    rd(8'hFD, 1, 'h41, 'h41);
    rd(8'hFD, 1, 'h42, 'h42);
    pulse(8'hFD, 1'b0, 1'b1);
    rd(8'hFD, 1, 'h41, 'h41);
    pulse(8'h10, 1'b1, 1'b0);
    rd(8'hFD, 1, 'h42, 'h42);

    // channel independence
    do_reset();
    rd(8'hFD, 1, 'h41, 'h41);
    rd(8'hFD, 1, 'h42, 'h42);
    rd(8'hFE, 1, 'h61, 'h61);
    rd(8'hFD, 1, 'h43, 'h43);
    rd(8'hFF, 1, 'h54, 'h54);

    // long strobe, then address switch while reading
    do_reset();
    rd(8'hFF, 5, 'h54, 'h54);
    rd(8'hFF, 1, 'h32, 'h32);
    @(posedge clk); #2;
    zxuno_addr = 8'hFF; zxuno_regrd = 1'b1; set_lit('h30, 'h30, 1'b0);
    repeat (2) @(negedge clk);
    #1 lit_on = 2'b00;
    @(posedge clk); #2;
    zxuno_addr = 8'hFE; set_lit('h61, 'h61, 1'b0);
    repeat (2) @(negedge clk);
    #1 lit_on = 2'b00;
    @(posedge clk); #2 zxuno_regrd = 1'b0;
    rd(8'hFF, 1, 'h2D, 'h2D);
    rd(8'hFE, 1, 'h62, 'h62);

    // asynchronous reset in the middle of a read at pointer 7
    do_reset();
    for (int i = 0; i < 7; i++) rd(8'hFF, 1, c2[i], c2[i]);
    @(posedge clk); #2;
    zxuno_addr = 8'hFF; zxuno_regrd = 1'b1; set_lit(c2[7], c2[7], 1'b0);
    @(negedge clk); #1 lit_on = 2'b00;
    @(posedge clk); #2;
    rst_n = 1'b0; set_lit('h54, 'h54, 1'b0);
    @(negedge clk); #1 lit_on = 2'b00;
    @(posedge clk); #2 zxuno_regrd = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    rd(8'hFF, 1, 'h54, 'h54);
    rd(8'h10, 3, 0, 0, 1'b1);
    rd(8'hFF, 1, 'h32, 'h32);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0: zxuno_addr = 8'hFC;
          1: zxuno_addr = 8'hFD;
          2: zxuno_addr = 8'hFE;
          3: zxuno_addr = 8'hFF;
          4: zxuno_addr = 8'h10;
          default: zxuno_addr = 8'($urandom_range(0, 255));
        endcase
      end
      if ($urandom_range(0, 2) == 0) zxuno_regrd = ~zxuno_regrd;
      regaddr_changed = ($urandom_range(0, 15) == 0);
      zxuno_regwr     = ($urandom_range(0, 19) == 0);
    end
    @(posedge clk); #2;
    zxuno_regrd = 1'b0; regaddr_changed = 1'b0; zxuno_regwr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1 chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
